// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared constants and helpers for the router FIFO array
package router_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_NUM_PORTS  = 4;
    localparam int DEFAULT_FIFO_DEPTH = 4;
    localparam int DROP_CNT_WIDTH     = 16;

    // Depth is a power of two >= 2, so pointers wrap naturally at this width.
    function automatic int ptr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/router_fifo.sv
// rtl/router_fifo.sv - single-clock synchronous FIFO with registered head, no fall-through
module router_fifo
    import router_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic                  full,
    output logic                  empty,
    output logic [DATA_WIDTH-1:0] head
);

    localparam int PTR_W = ptr_width(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is deliberately left out of reset; count/pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/router_fifo_array.sv
// rtl/router_fifo_array.sv - address-steered per-port FIFOs; ROUTER_DROP_CNT_EN enables the drop counter
module router_fifo_array
    import router_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int NUM_PORTS  = DEFAULT_NUM_PORTS,
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int ADDR_WIDTH = $clog2(NUM_PORTS)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [DATA_WIDTH-1:0]           din,
    input  logic                            din_en,
    input  logic [ADDR_WIDTH-1:0]           addr,
    output logic                            din_ready,
    output logic [NUM_PORTS*DATA_WIDTH-1:0] dout,
    output logic [NUM_PORTS-1:0]            dout_valid,
    input  logic [NUM_PORTS-1:0]            dout_ready,
    output logic [DROP_CNT_WIDTH-1:0]       drop_cnt
);

    localparam int ADDR_SPAN = 1 << ADDR_WIDTH;

    logic [NUM_PORTS-1:0]  full;
    logic [NUM_PORTS-1:0]  empty;
    logic [NUM_PORTS-1:0]  push;
    logic [NUM_PORTS-1:0]  pop;
    logic [ADDR_SPAN-1:0]  full_ext;
    logic [DATA_WIDTH-1:0] head [NUM_PORTS];
    logic                  accept;

    // Unused address codes read as never-full, so illegal beats are always taken.
    always_comb begin
        full_ext                  = '0;
        full_ext[NUM_PORTS-1:0]   = full;
    end

    assign din_ready = rst_n && !full_ext[addr];
    assign accept    = din_en && din_ready;
    assign pop       = dout_valid & dout_ready;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        assign push[p] = accept && (addr == ADDR_WIDTH'(p));

        router_fifo #(
            .DATA_WIDTH (DATA_WIDTH),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (push[p]),
            .push_data (din),
            .pop       (pop[p]),
            .full      (full[p]),
            .empty     (empty[p]),
            .head      (head[p])
        );

        assign dout_valid[p]                        = !empty[p];
        assign dout[p*DATA_WIDTH +: DATA_WIDTH]     = empty[p] ? '0 : head[p];
    end

`ifdef ROUTER_DROP_CNT_EN
    logic illegal_addr;

    assign illegal_addr = ({1'b0, addr} >= (ADDR_WIDTH+1)'(NUM_PORTS));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (accept && illegal_addr && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_router_fifo_array.sv
// tb/tb_router_fifo_array.sv - scoreboard bench for router_fifo_array
module tb_router_fifo_array;
    import router_pkg::*;

    localparam int DW    = 32;
    localparam int NP    = 4;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic             clk;
    logic             rst_n;
    logic [DW-1:0]    din;
    logic             din_en;
    logic [AW-1:0]    addr;
    logic             din_ready;
    logic [NP*DW-1:0] dout;
    logic [NP-1:0]    dout_valid;
    logic [NP-1:0]    dout_ready;
    logic [15:0]      drop_cnt;

    logic [DW-1:0]    din3;
    logic             din_en3;
    logic [1:0]       addr3;
    logic             din_ready3;
    logic [3*DW-1:0]  dout3;
    logic [2:0]       dout_valid3;
    logic [2:0]       dout_ready3;
    logic [15:0]      drop_cnt3;

    int checks = 0;
    int errors = 0;
    int drops3 = 0;
    logic [DW-1:0] sb [NP][$];
    bit  pop_now [NP];
    bit  mon_en = 0;

    router_fifo_array #(.DATA_WIDTH(DW), .NUM_PORTS(NP), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_en(din_en), .addr(addr),
        .din_ready(din_ready), .dout(dout), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .drop_cnt(drop_cnt)
    );

    router_fifo_array #(.DATA_WIDTH(DW), .NUM_PORTS(3), .FIFO_DEPTH(DEPTH)) dut3 (
        .clk(clk), .rst_n(rst_n), .din(din3), .din_en(din_en3), .addr(addr3),
        .din_ready(din_ready3), .dout(dout3), .dout_valid(dout_valid3),
        .dout_ready(dout_ready3), .drop_cnt(drop_cnt3)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: occupancy and head order come only from the per-port reference queues.
    always @(negedge clk) begin
        for (int p = 0; p < NP; p++) begin
            pop_now[p] <= 1'b0;
            if (mon_en && rst_n) begin
                check($sformatf("valid_p%0d", p), dout_valid[p], sb[p].size() != 0);
                if (dout_valid[p] && dout_ready[p] && sb[p].size() > 0) begin
                    check($sformatf("data_p%0d", p), dout[p*DW +: DW], sb[p].pop_front());
                    pop_now[p] <= 1'b1;
                end else if (!dout_valid[p]) begin
                    check($sformatf("zero_p%0d", p), dout[p*DW +: DW], '0);
                end
            end
        end
    end

    task automatic cyc(input bit en, input logic [AW-1:0] a, input logic [DW-1:0] d, output bit acc);
        bit exp_rdy;
        din_en = en;
        addr   = a;
        din    = d;
        @(negedge clk);
        #1;
        exp_rdy = rst_n && ((sb[a].size() + int'(pop_now[a])) < DEPTH);
        check("din_ready", din_ready, exp_rdy);
        acc = en && din_ready;
        if (acc) sb[a].push_back(d);
        @(posedge clk);
        #1;
        din_en = 0;
    endtask

    task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] d, input int budget, output bit ok);
        bit acc;
        ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            cyc(1'b1, a, d, acc);
            ok = acc;
        end
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, acc);
    endtask

    task automatic do_reset();
        bit acc;
        rst_n = 0;
        for (int p = 0; p < NP; p++) sb[p].delete();
        cyc(1'b1, '0, 32'hDEAD, acc);
        rst_n = 1;
        check("rst_valid", dout_valid, '0);
        check("rst_dout", dout, '0);
        check("rst_drop", drop_cnt, '0);
        check("rst_drop3", drop_cnt3, '0);
        check("rst_valid3", dout_valid3, '0);
        mon_en = 1;
    endtask

    initial begin
        bit ok;
        bit acc;
        logic [AW-1:0] ra;
        rst_n = 0; din = '0; din_en = 0; addr = '0; dout_ready = '0;
        din3 = '0; din_en3 = 0; addr3 = '0; dout_ready3 = '1;
        @(posedge clk); @(posedge clk); #1;
        do_reset();

        dout_ready = '1;
        for (int p = 0; p < NP; p++) begin
            send(AW'(p), DW'(32'hA0 + p), 4, ok);
            check("basic_send", ok, 1'b1);
        end
        idle(3);

        dout_ready = 4'b1011;
        for (int i = 0; i < DEPTH; i++) begin
            send(2'd2, DW'(32'hB0 + i), 2, ok);
            check("stall_fill", ok, 1'b1);
        end
        cyc(1'b1, 2'd2, 32'hB4, acc);
        check("full_blocks", acc, 1'b0);
        cyc(1'b1, 2'd1, 32'hC1, acc);
        check("other_port", acc, 1'b1);
        dout_ready = 4'b1111;
        send(2'd2, 32'hB4, 10, ok);
        check("fifth_after_drain", ok, 1'b1);
        idle(8);

        dout_ready = 4'b1110;
        send(2'd0, 32'hD0, 2, ok);
        send(2'd0, 32'hD1, 2, ok);
        dout_ready = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            check("pushpop_valid", dout_valid[0], 1'b1);
            cyc(1'b1, 2'd0, DW'(32'hE0 + i), acc);
            check("pushpop_acc", acc, 1'b1);
        end
        idle(6);

        for (int i = 0; i < 300; i++) begin
            dout_ready = NP'($urandom);
            ra = AW'($urandom);
            cyc(($urandom % 4) != 0, ra, DW'($urandom), acc);
        end
        dout_ready = '1;
        idle(10);
        for (int p = 0; p < NP; p++) check("drained", sb[p].size(), 0);

        dout_ready = 4'b1101;
        for (int i = 0; i < 3; i++) send(2'd1, DW'(32'hF0 + i), 2, ok);
        rst_n = 0;
        for (int p = 0; p < NP; p++) sb[p].delete();
        cyc(1'b0, '0, '0, acc);
        rst_n = 1;
        check("reset_flush", dout_valid[1], 1'b0);
        dout_ready = '1;
        send(2'd1, 32'h55, 2, ok);
        check("post_reset_valid", dout_valid[1], 1'b1);
        check("post_reset_data", dout[DW +: DW], 32'h55);
        idle(3);

        for (int i = 0; i < 3; i++) begin
            din_en3 = 1; addr3 = 2'd3; din3 = DW'(i);
            @(negedge clk); #1;
            check("illegal_ready", din_ready3, 1'b1);
            if (din_ready3) drops3++;
            @(posedge clk); #1;
        end
        din_en3 = 0;
`ifdef ROUTER_DROP_CNT_EN
        check("drop_cnt", drop_cnt3, drops3);
`else
        check("drop_cnt", drop_cnt3, 0);
`endif
        check("illegal_no_valid", dout_valid3, '0);
        check("main_drop_cnt", drop_cnt, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
